// File: rtl/dram_addr_seq.sv
// RAS/CAS/WE and 74F257 address-mux sequencer for the main DRAM array.
// Serves CPU accesses and periodic CAS-before-RAS refresh; all outputs are registered.
module dram_addr_seq #(
  parameter int T_RAS_TO_MUX     = 1,
  parameter int T_CAS            = 2,
  parameter int T_PRE            = 2,
  parameter int REFRESH_INTERVAL = 125,
  parameter int REF_W            = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic write,
  output logic ack,
  output logic busy,
  output logic ras_n,
  output logic cas_n,
  output logic we_n,
  output logic mux_sel,
  output logic mux_oe_n
);

  typedef enum logic [2:0] {
    IDLE, ROW, COL, CAS, RF_CAS, RF_RAS, PRE
  } state_t;

  localparam int RF_RAS_LEN = T_RAS_TO_MUX + 1 + T_CAS;
  localparam int DW_MAX     = (RF_RAS_LEN > T_PRE) ? RF_RAS_LEN : T_PRE;
  localparam int DW_W       = $clog2(DW_MAX + 1);

  localparam logic [DW_W-1:0]  ROW_LD    = DW_W'(T_RAS_TO_MUX - 1);
  localparam logic [DW_W-1:0]  CAS_LD    = DW_W'(T_CAS - 1);
  localparam logic [DW_W-1:0]  RF_RAS_LD = DW_W'(RF_RAS_LEN - 1);
  localparam logic [DW_W-1:0]  PRE_LD    = DW_W'(T_PRE - 1);
  localparam logic [REF_W-1:0] REF_LD    = REF_W'(REFRESH_INTERVAL - 1);

  state_t            state_reg, state_next;
  logic [DW_W-1:0]   dwell_reg, dwell_next;
  logic [REF_W-1:0]  ref_cnt_reg, ref_cnt_next;
  logic              pending_reg, pending_next;
  logic              write_reg, write_next;

  logic ack_next, busy_next, ras_n_next, cas_n_next, we_n_next;
  logic mux_sel_next, mux_oe_n_next;
  logic dwell_done, ref_expire, refresh_due, take_refresh;

  assign dwell_done  = (dwell_reg == '0);
  assign ref_expire  = (ref_cnt_reg == '0);
  // An expiry in the arbitration cycle itself already beats a competing req.
  assign refresh_due = pending_reg | ref_expire;

  always_comb begin
    state_next   = state_reg;
    dwell_next   = dwell_done ? '0 : dwell_reg - 1'b1;
    write_next   = write_reg;
    take_refresh = 1'b0;

    case (state_reg)
      IDLE, PRE: begin
        // Leaving PRE arbitrates exactly like IDLE, so back-to-back work loses no cycle.
        if (state_reg == IDLE || dwell_done) begin
          if (refresh_due) begin
            state_next   = RF_CAS;
            dwell_next   = '0;
            take_refresh = 1'b1;
          end else if (req) begin
            state_next = ROW;
            dwell_next = ROW_LD;
            write_next = write;
          end else begin
            state_next = IDLE;
            dwell_next = '0;
          end
        end
      end
      ROW: begin
        if (dwell_done) begin
          state_next = COL;
          dwell_next = '0;
        end
      end
      COL: begin
        state_next = CAS;
        dwell_next = CAS_LD;
      end
      CAS: begin
        if (dwell_done) begin
          state_next = PRE;
          dwell_next = PRE_LD;
        end
      end
      RF_CAS: begin
        state_next = RF_RAS;
        dwell_next = RF_RAS_LD;
      end
      RF_RAS: begin
        if (dwell_done) begin
          state_next = PRE;
          dwell_next = PRE_LD;
        end
      end
      default: begin
        state_next = IDLE;
        dwell_next = '0;
      end
    endcase
  end

  always_comb begin
    ref_cnt_next = ref_expire ? REF_LD : ref_cnt_reg - 1'b1;
    pending_next = (pending_reg | ref_expire) & ~take_refresh;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    ack_next      = 1'b0;
    busy_next     = (state_next != IDLE);
    ras_n_next    = 1'b1;
    cas_n_next    = 1'b1;
    we_n_next     = 1'b1;
    mux_sel_next  = 1'b0;
    mux_oe_n_next = 1'b0;
    case (state_next)
      ROW: ras_n_next = 1'b0;
      COL: begin
        ras_n_next   = 1'b0;
        mux_sel_next = 1'b1;
      end
      CAS: begin
        ras_n_next   = 1'b0;
        cas_n_next   = 1'b0;
        mux_sel_next = 1'b1;
        we_n_next    = ~write_next;
        ack_next     = (dwell_next == '0);
      end
      RF_CAS: begin
        cas_n_next    = 1'b0;
        mux_oe_n_next = 1'b1;
      end
      RF_RAS: begin
        cas_n_next    = 1'b0;
        ras_n_next    = 1'b0;
        mux_oe_n_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      dwell_reg   <= '0;
      ref_cnt_reg <= REF_LD;
      pending_reg <= 1'b0;
      write_reg   <= 1'b0;
      ack         <= 1'b0;
      busy        <= 1'b0;
      ras_n       <= 1'b1;
      cas_n       <= 1'b1;
      we_n        <= 1'b1;
      mux_sel     <= 1'b0;
      mux_oe_n    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dwell_reg   <= dwell_next;
      ref_cnt_reg <= ref_cnt_next;
      pending_reg <= pending_next;
      write_reg   <= write_next;
      ack         <= ack_next;
      busy        <= busy_next;
      ras_n       <= ras_n_next;
      cas_n       <= cas_n_next;
      we_n        <= we_n_next;
      mux_sel     <= mux_sel_next;
      mux_oe_n    <= mux_oe_n_next;
    end
  end

endmodule

// File: tb/tb_dram_addr_seq.sv
// Directed bench for dram_addr_seq: default instance for accesses/reset,
// REFRESH_INTERVAL=10 instance for refresh timing and refresh-vs-req arbitration.
module tb_dram_addr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, req, write;
  logic ack, busy, ras_n, cas_n, we_n, mux_sel, mux_oe_n;
  logic reset_rf, req_rf, write_rf;
  logic ack_rf, busy_rf, ras_n_rf, cas_n_rf, we_n_rf, mux_sel_rf, mux_oe_n_rf;

  int n_compared = 0;
  int n_mismatched = 0;

  // Bit order: {ack, busy, ras_n, cas_n, we_n, mux_sel, mux_oe_n}
  localparam logic [6:0] O_IDLE = 7'b0011100;
  localparam logic [6:0] O_ROW  = 7'b0101100;
  localparam logic [6:0] O_COL  = 7'b0101110;
  localparam logic [6:0] O_CASR = 7'b0100110;
  localparam logic [6:0] O_ACKR = 7'b1100110;
  localparam logic [6:0] O_PRE  = 7'b0111100;
  localparam logic [6:0] O_RFC  = 7'b0110101;
  localparam logic [6:0] O_RFR  = 7'b0100101;

  dram_addr_seq dut (
    .clk(clk), .reset(reset), .req(req), .write(write),
    .ack(ack), .busy(busy), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .mux_sel(mux_sel), .mux_oe_n(mux_oe_n)
  );

  dram_addr_seq #(.REFRESH_INTERVAL(10)) dut_rf (
    .clk(clk), .reset(reset_rf), .req(req_rf), .write(write_rf),
    .ack(ack_rf), .busy(busy_rf), .ras_n(ras_n_rf), .cas_n(cas_n_rf), .we_n(we_n_rf),
    .mux_sel(mux_sel_rf), .mux_oe_n(mux_oe_n_rf)
  );

  wire [6:0] out_vec    = {ack, busy, ras_n, cas_n, we_n, mux_sel, mux_oe_n};
  wire [6:0] out_vec_rf = {ack_rf, busy_rf, ras_n_rf, cas_n_rf, we_n_rf, mux_sel_rf, mux_oe_n_rf};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %b expected %b", tag, obs[6:0], exp[6:0]);
    end else begin
      $display("ok   %s: %b", tag, obs[6:0]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One access from IDLE: req at E0, dropped right after the ack cycle.
  task automatic do_access(input bit w, input bit toggle, input string tag);
    logic [6:0] exp_tab [7];
    exp_tab = '{O_ROW, O_COL, O_CASR, O_ACKR, O_PRE, O_PRE, O_IDLE};
    if (w) begin
      exp_tab[2][2] = 1'b0;
      exp_tab[3][2] = 1'b0;
    end
    req   = 1'b1;
    write = w;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("%s_E%0d", tag, i), {25'd0, out_vec}, {25'd0, exp_tab[i]});
      if (i == 2 && toggle) write = ~w;
      if (i == 3) req = 1'b0;
    end
  endtask

  function automatic logic [6:0] rf_expect(input int k);
    logic [6:0] tail [14];
    int p;
    tail = '{O_RFC, O_RFR, O_RFR, O_RFR, O_RFR, O_PRE, O_PRE,
             O_ROW, O_COL, O_CASR, O_ACKR, O_PRE, O_PRE, O_RFC};
    if (k < 10) return O_IDLE;
    if (k >= 40) return tail[k - 40];
    p = k % 10;
    if (p == 0) return O_RFC;
    if (p <= 4) return O_RFR;
    if (p <= 6) return O_PRE;
    return O_IDLE;
  endfunction

  initial begin
    reset = 1'b1; req = 1'b0; write = 1'b0;
    reset_rf = 1'b1; req_rf = 1'b0; write_rf = 1'b0;

    tick();
    tick();
    check_eq("reset", {25'd0, out_vec}, {25'd0, O_IDLE});
    check_eq("reset_rf", {25'd0, out_vec_rf}, {25'd0, O_IDLE});
    reset = 1'b0;
    tick();
    check_eq("idle", {25'd0, out_vec}, {25'd0, O_IDLE});

    do_access(1'b0, 1'b0, "rd");
    do_access(1'b1, 1'b1, "wr");

    // Abort an access in its first CAS cycle.
    req = 1'b1;
    write = 1'b0;
    tick(); check_eq("abort_E0", {25'd0, out_vec}, {25'd0, O_ROW});
    tick(); check_eq("abort_E1", {25'd0, out_vec}, {25'd0, O_COL});
    tick(); check_eq("abort_E2", {25'd0, out_vec}, {25'd0, O_CASR});
    reset = 1'b1;
    req = 1'b0;
    tick(); check_eq("abort_rst", {25'd0, out_vec}, {25'd0, O_IDLE});
    reset = 1'b0;
    tick(); check_eq("abort_idle", {25'd0, out_vec}, {25'd0, O_IDLE});
    do_access(1'b0, 1'b0, "post");

    // Refresh every 10 cycles, then a req arriving on an expiry cycle at edge 40.
    reset_rf = 1'b0;
    for (int k = 1; k <= 53; k++) begin
      tick();
      check_eq($sformatf("rf_k%0d", k), {25'd0, out_vec_rf}, {25'd0, rf_expect(k)});
      if (k == 39) req_rf = 1'b1;
      if (k == 50) req_rf = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
